// File: rtl/jtag_cmd_sequencer_if.sv
// jtag_cmd_sequencer_if: groups the command-FIFO pop port, the response-FIFO push port,
// the 32-bit bus master port and the status/control flags of the sequencer.
//   cmd_empty/cmd_data/cmd_rd_en : command FIFO read side (byte wide)
//   rsp_full/rsp_wr_en/rsp_data  : response FIFO write side (byte wide)
//   bus_*                        : req/ack bus master port
//   busy/bad_op/clr_err          : status and sticky-error clear
// Modport slave is the sequencer side; master is the environment side.
interface jtag_cmd_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_empty;
    logic [7:0]        cmd_data;
    logic              cmd_rd_en;
    logic              rsp_full;
    logic              rsp_wr_en;
    logic [7:0]        rsp_data;
    logic              bus_req;
    logic              bus_wen;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;
    logic              busy;
    logic              bad_op;
    logic              clr_err;

    modport slave (
        input  cmd_empty, cmd_data, rsp_full, bus_ack, bus_rdata, bus_err, clr_err,
        output cmd_rd_en, rsp_wr_en, rsp_data, bus_req, bus_wen, bus_addr, bus_wdata,
               busy, bad_op
    );

    modport master (
        output cmd_empty, cmd_data, rsp_full, bus_ack, bus_rdata, bus_err, clr_err,
        input  cmd_rd_en, rsp_wr_en, rsp_data, bus_req, bus_wen, bus_addr, bus_wdata,
               busy, bad_op
    );
endinterface

// File: rtl/jtag_cmd_sequencer.sv
// jtag_cmd_sequencer: TCK-domain controller that pops little-endian command packets
// (opcode, address, optional write data) from the command FIFO, runs one req/ack bus
// transaction with a timeout, and pushes read data plus a status byte into the
// response FIFO.
//   TCK  : clock, all logic on posedge
//   TRST : asynchronous active-low reset
//   sif  : slave modport carrying the command, response, bus and status signals
// Status byte: 0x00 ok, 0x01 bus error, 0x02 timeout.
module jtag_cmd_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 TCK,
    input logic                 TRST,
    jtag_cmd_sequencer_if.slave sif
);
    localparam int unsigned ABYTES = ADDR_W / 8;
    localparam int unsigned DBYTES = DATA_W / 8;
    localparam int unsigned MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
    // Must also hold DBYTES, the index of the trailing status byte in a read response.
    localparam int unsigned CNT_W  = $clog2(MAXB + 1);

    typedef enum logic [2:0] {StIdle, StAddr, StWdata, StBus, StRsp} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        tmo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;   // doubles as the response shift register
    logic [7:0]        status_q;
    logic [7:0]        rsp_data_q;
    logic              is_wr_q;
    logic              bus_req_q;
    logic              bad_op_q;

    logic              pop;
    logic              push;
    logic              a_last;
    logic              d_last;
    logic              rsp_last;
    logic              tmo_hit;
    logic [7:0]        ack_status;
    logic [DATA_W-1:0] rd_shift;

    always_comb begin
        pop        = (state_q inside {StIdle, StAddr, StWdata}) && !sif.cmd_empty;
        push       = (state_q == StRsp) && !sif.rsp_full;
        a_last     = (cnt_q == CNT_W'(ABYTES - 1));
        d_last     = (cnt_q == CNT_W'(DBYTES - 1));
        rsp_last   = is_wr_q || (cnt_q == CNT_W'(DBYTES));
        tmo_hit    = (tmo_q == 8'(TIMEOUT - 1));
        ack_status = sif.bus_err ? 8'h01 : 8'h00;
        rd_shift   = rdata_q >> 8;
    end

    assign sif.cmd_rd_en = pop;
    assign sif.rsp_wr_en = push;
    assign sif.rsp_data  = rsp_data_q;
    assign sif.bus_req   = bus_req_q;
    assign sif.bus_wen   = is_wr_q;
    assign sif.bus_addr  = addr_q;
    assign sif.bus_wdata = wdata_q;
    assign sif.busy      = (state_q != StIdle);
    assign sif.bad_op    = bad_op_q;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= '0;
            rsp_data_q <= '0;
            is_wr_q    <= 1'b0;
            bus_req_q  <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            // A set in the Idle branch below overrides this clear.
            if (sif.clr_err) bad_op_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        cnt_q <= '0;
                        case (sif.cmd_data)
                            8'h00: ;
                            8'h01: begin is_wr_q <= 1'b1; state_q <= StAddr; end
                            8'h02: begin is_wr_q <= 1'b0; state_q <= StAddr; end
                            default: bad_op_q <= 1'b1;
                        endcase
                    end
                end
                StAddr: begin
                    if (pop) begin
                        addr_q[{cnt_q, 3'b000} +: 8] <= sif.cmd_data;
                        if (a_last) begin
                            cnt_q <= '0;
                            if (is_wr_q) begin
                                state_q <= StWdata;
                            end else begin
                                state_q   <= StBus;
                                bus_req_q <= 1'b1;
                                tmo_q     <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StWdata: begin
                    if (pop) begin
                        wdata_q[{cnt_q, 3'b000} +: 8] <= sif.cmd_data;
                        if (d_last) begin
                            cnt_q     <= '0;
                            state_q   <= StBus;
                            bus_req_q <= 1'b1;
                            tmo_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StBus: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (sif.bus_ack) begin
                        bus_req_q  <= 1'b0;
                        state_q    <= StRsp;
                        cnt_q      <= '0;
                        status_q   <= ack_status;
                        rdata_q    <= sif.bus_err ? '0 : sif.bus_rdata;
                        rsp_data_q <= is_wr_q ? ack_status
                                              : (sif.bus_err ? 8'h00 : sif.bus_rdata[7:0]);
                    end else if (tmo_hit) begin
                        bus_req_q  <= 1'b0;
                        state_q    <= StRsp;
                        cnt_q      <= '0;
                        status_q   <= 8'h02;
                        rdata_q    <= '0;
                        rsp_data_q <= is_wr_q ? 8'h02 : 8'h00;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StRsp: begin
                    if (push) begin
                        if (rsp_last) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            rdata_q    <= rd_shift;
                            rsp_data_q <= d_last ? status_q : rd_shift[7:0];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Scoreboard bench for jtag_cmd_sequencer: stimulus pushes command bytes plus the
// expected bus transaction and response bytes; a negedge monitor checks every bus
// cycle and every response push against those queues.
module tb_jtag_cmd_sequencer;
    logic TCK = 1'b0;
    logic TRST;
    always #5 TCK = ~TCK;

    jtag_cmd_sequencer_if #(.ADDR_W(32), .DATA_W(32)) sif ();

    jtag_cmd_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .sif  (sif)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        int          len;
    } bus_exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  cmd_q[$];
    logic [7:0]  exp_rsp[$];
    bus_exp_t    bus_q[$];
    logic        will_pop = 1'b0;
    int          req_cycles = 0;
    int          ack_delay = 1;
    logic        never_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Command FIFO model: pops after the edge that consumed, then re-presents the head.
    always @(posedge TCK) begin
        #1;
        if (will_pop && cmd_q.size() > 0) void'(cmd_q.pop_front());
        #1;
        sif.cmd_empty = (cmd_q.size() == 0);
        sif.cmd_data  = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
    end

    // Monitor and bus slave model.
    always @(negedge TCK) begin
        if (sif.cmd_empty) chk("pop_while_empty", 64'(sif.cmd_rd_en), 64'd0);
        if (sif.rsp_full) chk("push_while_full", 64'(sif.rsp_wr_en), 64'd0);
        if (sif.rsp_wr_en) begin
            if (exp_rsp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got 0x%0h, want no push", sif.rsp_data);
            end else begin
                chk("rsp_byte", 64'(sif.rsp_data), 64'(exp_rsp.pop_front()));
            end
        end
        if (sif.bus_req) begin
            req_cycles++;
            if (bus_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_bus_req: got addr 0x%0h, want no request",
                         sif.bus_addr);
            end else begin
                chk("bus_addr", 64'(sif.bus_addr), 64'(bus_q[0].addr));
                chk("bus_wen", 64'(sif.bus_wen), 64'(bus_q[0].wen));
                if (bus_q[0].wen) chk("bus_wdata", 64'(sif.bus_wdata), 64'(bus_q[0].wdata));
            end
            sif.bus_ack = !never_ack && (req_cycles == ack_delay);
        end else begin
            sif.bus_ack = 1'b0;
            if (req_cycles > 0) begin
                if (bus_q.size() > 0) begin
                    chk("bus_req_len", 64'(req_cycles), 64'(bus_q[0].len));
                    void'(bus_q.pop_front());
                end
                req_cycles = 0;
            end
        end
        will_pop = sif.cmd_rd_en;
    end

    task automatic push_pkt(input logic [79:0] v, input int n);
        @(posedge TCK);
        #1;
        for (int i = 0; i < n; i++) cmd_q.push_back(v[8*i +: 8]);
    endtask

    task automatic exp_bytes(input logic [39:0] v, input int n);
        for (int i = 0; i < n; i++) exp_rsp.push_back(v[8*i +: 8]);
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int len);
        bus_exp_t e;
        e.addr  = a;
        e.wen   = w;
        e.wdata = d;
        e.len   = len;
        bus_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        @(negedge TCK);
        while (!(cmd_q.size() == 0 && !sif.busy && exp_rsp.size() == 0 && bus_q.size() == 0)
               && n < bound) begin
            @(negedge TCK);
            n++;
        end
        total++;
        if (n >= bound) begin
            bad++;
            $display("FAIL %s_done: got no completion in %0d cycles, want completion",
                     name, bound);
            cmd_q.delete();
            exp_rsp.delete();
            bus_q.delete();
        end
        repeat (2) @(negedge TCK);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_cmd_rd_en"}, 64'(sif.cmd_rd_en), 64'd0);
        chk({name, "_rsp_wr_en"}, 64'(sif.rsp_wr_en), 64'd0);
        chk({name, "_rsp_data"},  64'(sif.rsp_data),  64'd0);
        chk({name, "_bus_req"},   64'(sif.bus_req),   64'd0);
        chk({name, "_bus_wen"},   64'(sif.bus_wen),   64'd0);
        chk({name, "_bus_addr"},  64'(sif.bus_addr),  64'd0);
        chk({name, "_bus_wdata"}, 64'(sif.bus_wdata), 64'd0);
        chk({name, "_busy"},      64'(sif.busy),      64'd0);
        chk({name, "_bad_op"},    64'(sif.bad_op),    64'd0);
    endtask

    initial begin
        int n;
        TRST          = 1'b0;
        sif.cmd_empty = 1'b1;
        sif.cmd_data  = 8'h00;
        sif.rsp_full  = 1'b0;
        sif.bus_ack   = 1'b0;
        sif.bus_rdata = '0;
        sif.bus_err   = 1'b0;
        sif.clr_err   = 1'b0;
        #2;
        check_zero("reset");
        repeat (3) @(posedge TCK);
        #1 TRST = 1'b1;

        // WRITE, ack in the first request cycle.
        ack_delay = 1;
        exp_bus(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 1);
        exp_bytes(40'h00, 1);
        push_pkt(80'hDE_AD_BE_EF_40_00_00_10_01, 9);
        wait_done("write", 200);

        // NOP then READ, ack after 3 cycles.
        ack_delay     = 3;
        sif.bus_rdata = 32'h1234_5678;
        exp_bus(32'h0000_0100, 1'b0, 32'h0, 3);
        exp_bytes(40'h00_12_34_56_78, 5);
        push_pkt(80'h00_00_01_00_02_00, 6);
        wait_done("read", 200);

        // READ acked with bus error: data bytes forced to zero.
        ack_delay     = 2;
        sif.bus_rdata = 32'h55AA_55AA;
        sif.bus_err   = 1'b1;
        exp_bus(32'h0000_0200, 1'b0, 32'h0, 2);
        exp_bytes(40'h01_00_00_00_00, 5);
        push_pkt(80'h00_00_02_00_02, 5);
        wait_done("read_err", 200);
        sif.bus_err = 1'b0;

        // READ never acked: request held exactly 255 cycles.
        never_ack     = 1'b1;
        sif.bus_rdata = 32'hCAFE_F00D;
        exp_bus(32'h0000_0300, 1'b0, 32'h0, 255);
        exp_bytes(40'h02_00_00_00_00, 5);
        push_pkt(80'h00_00_03_00_02, 5);
        wait_done("timeout", 2000);
        never_ack = 1'b0;

        // Command FIFO runs dry between address bytes 2 and 3.
        ack_delay = 2;
        exp_bus(32'h0A0B_0C0D, 1'b1, 32'h1122_3344, 2);
        exp_bytes(40'h00, 1);
        push_pkt(80'h0C_0D_01, 3);
        repeat (6) @(posedge TCK);
        push_pkt(80'h11_22_33_44_0A_0B, 6);
        wait_done("cmd_gap", 200);

        // Response FIFO full for 5 cycles after the first read byte.
        ack_delay     = 1;
        sif.bus_rdata = 32'hA1B2_C3D4;
        exp_bus(32'h0000_0400, 1'b0, 32'h0, 1);
        exp_bytes(40'h00_A1_B2_C3_D4, 5);
        push_pkt(80'h00_00_04_00_02, 5);
        n = 0;
        do begin
            @(negedge TCK);
            n++;
        end while (!sif.rsp_wr_en && n < 200);
        chk("stall_first_push_seen", 64'(sif.rsp_wr_en), 64'd1);
        @(posedge TCK);
        #1 sif.rsp_full = 1'b1;
        repeat (5) @(posedge TCK);
        #1 sif.rsp_full = 1'b0;
        wait_done("rsp_stall", 200);

        // Invalid opcode, then a normal WRITE; bad_op stays set until cleared.
        ack_delay = 1;
        exp_bus(32'h0000_0020, 1'b1, 32'h0000_0001, 1);
        exp_bytes(40'h00, 1);
        push_pkt(80'h7F, 1);
        push_pkt(80'h00_00_00_01_00_00_00_20_01, 9);
        wait_done("bad_op_write", 200);
        chk("bad_op_sticky", 64'(sif.bad_op), 64'd1);
        @(posedge TCK);
        #1 sif.clr_err = 1'b1;
        @(posedge TCK);
        #1 sif.clr_err = 1'b0;
        @(negedge TCK);
        chk("bad_op_cleared", 64'(sif.bad_op), 64'd0);
        // Invalid opcode popped in the same cycle as clr_err: set wins.
        @(posedge TCK);
        #1;
        sif.clr_err = 1'b1;
        cmd_q.push_back(8'h55);
        @(posedge TCK);
        #1 sif.clr_err = 1'b0;
        @(negedge TCK);
        chk("bad_op_set_wins", 64'(sif.bad_op), 64'd1);
        chk("bad_op_idle", 64'(sif.busy), 64'd0);
        @(posedge TCK);
        #1 sif.clr_err = 1'b1;
        @(posedge TCK);
        #1 sif.clr_err = 1'b0;

        // Reset while in WDATA after two data bytes.
        push_pkt(80'h77_66_80_00_12_34_01, 7);
        n = 0;
        while (cmd_q.size() > 0 && n < 100) begin
            @(negedge TCK);
            n++;
        end
        repeat (3) @(negedge TCK);
        chk("midop_busy", 64'(sif.busy), 64'd1);
        chk("midop_no_req", 64'(sif.bus_req), 64'd0);
        @(posedge TCK);
        #3 TRST = 1'b0;
        #1 check_zero("midop_reset");
        repeat (3) @(posedge TCK);
        #1 TRST = 1'b1;
        repeat (2) @(negedge TCK);
        chk("after_reset_idle", 64'(sif.busy), 64'd0);

        ack_delay = 1;
        exp_bus(32'h0000_0044, 1'b1, 32'h0BAD_F00D, 1);
        exp_bytes(40'h00, 1);
        push_pkt(80'h0B_AD_F0_0D_00_00_00_44_01, 9);
        wait_done("write_after_reset", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
